// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MemRead/MemWrite request bus between the CPU control path and data memory
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        busy;
  logic        ack;
  logic        readvalid;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output mem_read, mem_write, address, byteenable, writedata,
    input  busy, ack, readvalid, readdata, err
  );

  modport slave (
    input  mem_read, mem_write, address, byteenable, writedata,
    output busy, ack, readvalid, readdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated word memory answering one load/store at a time
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    readvalid_q, readvalid_d;
  logic                    err_q, err_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [31:0]             mem_q [2**ADDR_WIDTH];
  logic                    do_access;
  logic                    unused_addr;

  // Upper address bits alias silently
  assign unused_addr = ^bus.address[31:ADDR_WIDTH+2];

  assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    idx_d       = idx_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    readvalid_d = 1'b0;
    err_d       = 1'b0;
    readdata_d  = readdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          if ((bus.mem_read && bus.mem_write) || (bus.address[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            is_write_d = bus.mem_write;
            idx_d      = bus.address[ADDR_WIDTH+1:2];
            be_d       = bus.byteenable;
            wdata_d    = bus.writedata;
            cnt_d      = 4'(WAIT_STATES);
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (!is_write_q) begin
            readdata_d  = mem_q[idx_q];
            readvalid_d = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      is_write_q  <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'd0;
      wdata_q     <= 32'h0;
      readvalid_q <= 1'b0;
      err_q       <= 1'b0;
      readdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      readvalid_q <= readvalid_d;
      err_q       <= err_d;
      readdata_q  <= readdata_d;
    end
  end

  // Array has no reset; an async reset forces IDLE so an aborted store never lands
  always_ff @(posedge clk) begin
    if (do_access && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.ack       = (state_q == RESP);
  assign bus.readvalid = readvalid_q;
  assign bus.err       = err_q;
  assign bus.readdata  = readdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed checks of data_mem_responder at WAIT_STATES 2 and 0
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.address = addr;
      bus0.writedata = wd; bus0.byteenable = be;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.address = addr;
      bus1.writedata = wd; bus1.byteenable = be;
    end
  endtask

  // Edges counted include the accepting edge; ack is looked for #1 after each edge
  task automatic txn(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output int edges, output logic rv, output logic er, output logic [31:0] rdata);
    logic a;
    drive(d, rd, wr, addr, wd, be);
    edges = -1; rv = 1'bx; er = 1'bx; rdata = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      a = (d == 0) ? bus0.ack : bus1.ack;
      if (a) begin
        edges = i;
        rv    = (d == 0) ? bus0.readvalid : bus1.readvalid;
        er    = (d == 0) ? bus0.err : bus1.err;
        rdata = (d == 0) ? bus0.readdata : bus1.readdata;
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
  endtask

  task automatic store(input string tag, input int d, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    int e; logic rv, er; logic [31:0] rdt;
    txn(d, 1'b0, 1'b1, addr, wd, be, e, rv, er, rdt);
    check({tag, "_lat"}, e, (d == 0) ? 4 : 2);
    check({tag, "_err"}, {31'b0, er}, 32'd0);
    check({tag, "_rv"},  {31'b0, rv}, 32'd0);
  endtask

  task automatic load(input string tag, input int d, input logic [31:0] addr, input logic [31:0] exp);
    int e; logic rv, er; logic [31:0] rdt;
    txn(d, 1'b1, 1'b0, addr, 32'h0, 4'h0, e, rv, er, rdt);
    check({tag, "_lat"}, e, (d == 0) ? 4 : 2);
    check({tag, "_rv"},  {31'b0, rv}, 32'd1);
    check({tag, "_data"}, rdt, exp);
  endtask

  initial begin
    int e; int acks; int busy_cnt; logic rv, er; logic [31:0] rdt;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus0.busy}, 32'd0);
    check("rst_ack",  {31'b0, bus0.ack}, 32'd0);
    check("rst_rv",   {31'b0, bus0.readvalid}, 32'd0);
    check("rst_err",  {31'b0, bus0.err}, 32'd0);
    check("rst_rdata", bus0.readdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    store("st_beef", 0, 32'h10, 32'hDEADBEEF, 4'hF);
    check("ack_pulse", {31'b0, bus0.ack}, 32'd0);
    load("ld_beef", 0, 32'h10, 32'hDEADBEEF);
    store("st_be5", 0, 32'h10, 32'h11223344, 4'b0101);
    load("ld_be5", 0, 32'h10, 32'hDE22BE44);
    store("st_be0", 0, 32'h10, 32'h99999999, 4'b0000);
    load("ld_be0", 0, 32'h10, 32'hDE22BE44);

    txn(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, e, rv, er, rdt);
    check("mis_lat", e, 1);
    check("mis_err", {31'b0, er}, 32'd1);
    check("mis_rv",  {31'b0, rv}, 32'd0);
    check("mis_rdata", rdt, 32'hDE22BE44);

    store("st_20", 0, 32'h20, 32'hCAFEF00D, 4'hF);
    txn(0, 1'b1, 1'b1, 32'h20, 32'h0, 4'hF, e, rv, er, rdt);
    check("both_lat", e, 1);
    check("both_err", {31'b0, er}, 32'd1);
    load("ld_20", 0, 32'h20, 32'hCAFEF00D);

    store("st_alias", 0, 32'h400, 32'hA5A5A5A5, 4'hF);
    load("ld_alias", 0, 32'h000, 32'hA5A5A5A5);

    store("st_40", 0, 32'h40, 32'h12345678, 4'hF);
    drive(0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, bus0.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy0", {31'b0, bus0.busy}, 32'd0);
    check("abort_ack0",  {31'b0, bus0.ack}, 32'd0);
    check("abort_rv0",   {31'b0, bus0.readvalid}, 32'd0);
    check("abort_err0",  {31'b0, bus0.err}, 32'd0);
    check("abort_rdata", bus0.readdata, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus0.ack) acks++;
    end
    check("abort_noack", acks, 0);
    load("ld_40", 0, 32'h40, 32'h12345678);

    store("w0_st_c", 1, 32'h0C, 32'h0C0C0C0C, 4'hF);
    drive(1, 1'b0, 1'b1, 32'h08, 32'h00000077, 4'hF);
    busy_cnt = 0;
    e = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus1.busy) busy_cnt++;
      if (bus1.ack && e < 0) begin
        e = i;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end else if (i == 1) begin
        drive(1, 1'b0, 1'b1, 32'h0C, 32'h00000BAD, 4'h3);
      end
    end
    check("w0_lat", e, 2);
    check("w0_busy_cycles", busy_cnt, 2);
    load("w0_ld_8", 1, 32'h08, 32'h00000077);
    load("w0_ld_c", 1, 32'h0C, 32'h0C0C0C0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
